// File: rtl/pong_pkg.sv
// Shared types and screen constants for the pong referee slice.
package pong_pkg;

    localparam int POS_W    = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        SERVE_WAIT = 2'd0,
        PLAY       = 2'd1,
        PAUSE      = 2'd2,
        GAME_OVER  = 2'd3
    } referee_state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Brings a raw push-button into the clock domain and emits a one-cycle pulse
// on its rising edge.
module btn_sync_edge (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/score_referee.sv
// Pong referee: detects missed balls once per frame, emits score pulses,
// holds and re-serves the ball, and declares the match winner.
module score_referee
    import pong_pkg::*;
#(
    parameter logic [POS_W-1:0] TOP_LIMIT    = 10'd8,
    parameter logic [POS_W-1:0] BOTTOM_LIMIT = 10'd472,
    parameter logic [POS_W-1:0] BALL_SIZE    = 10'd8,
    parameter logic [POS_W-1:0] PADDLE_W     = 10'd64,
    parameter logic [7:0]       PAUSE_FRAMES = 8'd60,
    parameter logic [3:0]       WIN_SCORE    = 4'd9
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             frame_tick_i,
    input  logic [POS_W-1:0] ball_x_i,
    input  logic [POS_W-1:0] ball_y_i,
    input  logic [POS_W-1:0] top_pad_x_i,
    input  logic [POS_W-1:0] bot_pad_x_i,
    input  logic             start_ball_i,
    output logic             score_p1_o,
    output logic             score_p2_o,
    output logic             ball_hold_o,
    output logic             serve_dir_o,
    output logic             game_over_o,
    output logic             winner_o
);

    // One extra bit keeps ball_x+BALL_SIZE and pad_x+PADDLE_W from wrapping.
    function automatic logic overlaps(input logic [POS_W-1:0] bx,
                                      input logic [POS_W-1:0] px);
        logic [POS_W:0] bx_w;
        logic [POS_W:0] px_w;
        bx_w = {1'b0, bx};
        px_w = {1'b0, px};
        return ((bx_w + {1'b0, BALL_SIZE}) > px_w) &&
               (bx_w < (px_w + {1'b0, PADDLE_W}));
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] t);
        return (t >= WIN_SCORE) ? WIN_SCORE : t + 4'd1;
    endfunction

    referee_state_t state_q, state_d;
    logic [3:0] t1_q, t1_d;
    logic [3:0] t2_q, t2_d;
    logic [7:0] pause_q, pause_d;
    logic       score_p1_q, score_p1_d;
    logic       score_p2_q, score_p2_d;
    logic       serve_dir_q, serve_dir_d;
    logic       winner_q, winner_d;

    logic       start_pe;
    logic       p1_miss;
    logic       p2_miss;
    logic [3:0] t1_inc;
    logic [3:0] t2_inc;

    btn_sync_edge u_start_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .btn_i   (start_ball_i),
        .pulse_o (start_pe)
    );

    assign p1_miss = (ball_y_i >= BOTTOM_LIMIT) && !overlaps(ball_x_i, bot_pad_x_i);
    assign p2_miss = (ball_y_i <= TOP_LIMIT)    && !overlaps(ball_x_i, top_pad_x_i);
    assign t1_inc  = sat_inc(t1_q);
    assign t2_inc  = sat_inc(t2_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= SERVE_WAIT;
            t1_q        <= 4'd0;
            t2_q        <= 4'd0;
            pause_q     <= 8'd0;
            score_p1_q  <= 1'b0;
            score_p2_q  <= 1'b0;
            serve_dir_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            pause_q     <= pause_d;
            score_p1_q  <= score_p1_d;
            score_p2_q  <= score_p2_d;
            serve_dir_q <= serve_dir_d;
            winner_q    <= winner_d;
        end
    end

    // Player1 is checked first, so a frame crossing both lines scores only for p1.
    always_comb begin
        state_d     = state_q;
        t1_d        = t1_q;
        t2_d        = t2_q;
        pause_d     = pause_q;
        score_p1_d  = 1'b0;
        score_p2_d  = 1'b0;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        case (state_q)
            SERVE_WAIT: begin
                if (start_pe) state_d = PLAY;
            end
            PLAY: begin
                if (frame_tick_i && p1_miss) begin
                    t1_d        = t1_inc;
                    score_p1_d  = 1'b1;
                    serve_dir_d = 1'b1;
                    pause_d     = 8'd0;
                    if (t1_inc == WIN_SCORE) begin
                        state_d  = GAME_OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d = PAUSE;
                    end
                end else if (frame_tick_i && p2_miss) begin
                    t2_d        = t2_inc;
                    score_p2_d  = 1'b1;
                    serve_dir_d = 1'b0;
                    pause_d     = 8'd0;
                    if (t2_inc == WIN_SCORE) begin
                        state_d  = GAME_OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (frame_tick_i) begin
                    if (pause_q == PAUSE_FRAMES - 8'd1) begin
                        state_d = SERVE_WAIT;
                        pause_d = 8'd0;
                    end else begin
                        pause_d = pause_q + 8'd1;
                    end
                end
            end
            GAME_OVER: begin
                if (start_pe) begin
                    t1_d        = 4'd0;
                    t2_d        = 4'd0;
                    serve_dir_d = 1'b0;
                    state_d     = SERVE_WAIT;
                end
            end
            default: state_d = SERVE_WAIT;
        endcase
    end

    always_comb begin
        ball_hold_o = (state_q != PLAY);
        game_over_o = (state_q == GAME_OVER);
        winner_o    = winner_q;
        serve_dir_o = serve_dir_q;
        score_p1_o  = score_p1_q;
        score_p2_o  = score_p2_q;
    end

endmodule

// File: tb/tb_score_referee.sv
// Scoreboard bench for score_referee: stimulus queues expected score pulses,
// a monitor matches every pulse the DUT produces against that queue.
module tb_score_referee;

    logic       clk;
    logic       reset;
    logic       frameTick;
    logic [9:0] ballX;
    logic [9:0] ballY;
    logic [9:0] topPadX;
    logic [9:0] botPadX;
    logic       startBall;
    logic       scoreP1;
    logic       scoreP2;
    logic       ballHold;
    logic       serveDir;
    logic       gameOver;
    logic       winner;

    typedef struct {
        bit isP1;
        int cyc;
    } pulse_t;

    pulse_t expQ[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;

    score_referee dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .frame_tick_i (frameTick),
        .ball_x_i     (ballX),
        .ball_y_i     (ballY),
        .top_pad_x_i  (topPadX),
        .bot_pad_x_i  (botPadX),
        .start_ball_i (startBall),
        .score_p1_o   (scoreP1),
        .score_p2_o   (scoreP2),
        .ball_hold_o  (ballHold),
        .serve_dir_o  (serveDir),
        .game_over_o  (gameOver),
        .winner_o     (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every observed pulse must match the oldest expectation in kind and cycle.
    always @(negedge clk) begin : monitor
        pulse_t e;
        if (!reset && (scoreP1 || scoreP2)) begin
            checks++;
            if (scoreP1 && scoreP2) begin
                errors++;
                $display("[TB] FAIL pulse_both actual=p1:1,p2:1 expected=single pulse at cyc %0d", cyc);
            end else if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL pulse_unexpected actual=p1:%0b,p2:%0b expected=none at cyc %0d",
                         scoreP1, scoreP2, cyc);
            end else begin
                e = expQ.pop_front();
                if (e.isP1 != scoreP1 || e.cyc != cyc) begin
                    errors++;
                    $display("[TB] FAIL pulse_match actual=p1:%0b@%0d expected=p1:%0b@%0d",
                             scoreP1, cyc, e.isP1, e.cyc);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0b expected=%0b", name, actual, expected);
        end
    endtask

    // One frame_tick cycle followed by one idle cycle; returns on the cycle a pulse would show.
    task automatic applyStimulus(input bit expP1, input bit expP2);
        pulse_t e;
        @(negedge clk);
        frameTick = 1'b1;
        if (expP1 || expP2) begin
            e.isP1 = expP1;
            e.cyc  = cyc + 1;
            expQ.push_back(e);
        end
        @(negedge clk);
        frameTick = 1'b0;
    endtask

    task automatic runFrames(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        startBall = 1'b1;
        repeat (4) @(negedge clk);
        startBall = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Presses start and verifies ball_hold drops within 3..4 cycles.
    task automatic pressStart(input string name);
        int lat;
        @(negedge clk);
        startBall = 1'b1;
        lat = 99;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (!ballHold) begin
                lat = i;
                break;
            end
        end
        startBall = 1'b0;
        checks++;
        if (lat < 3 || lat > 4) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d cycles expected=3..4 cycles", name, lat);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic centreBall();
        ballX   = 10'd300;
        ballY   = 10'd240;
        topPadX = 10'd300;
        botPadX = 10'd300;
    endtask

    initial begin
        reset     = 1'b1;
        frameTick = 1'b0;
        startBall = 1'b0;
        centreBall();
        repeat (3) @(negedge clk);
        checkOutput("reset_hold", ballHold, 1'b1);
        checkOutput("reset_p1", scoreP1, 1'b0);
        checkOutput("reset_p2", scoreP2, 1'b0);
        checkOutput("reset_serve", serveDir, 1'b0);
        checkOutput("reset_gameover", gameOver, 1'b0);
        checkOutput("reset_winner", winner, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // frame_tick in SERVE_WAIT must not score.
        ballY = 10'd475; botPadX = 10'd0;
        runFrames(2);
        centreBall();
        pressStart("start_latency");
        checkOutput("play_hold", ballHold, 1'b0);

        // Paddle hits and near-line positions.
        ballY = 10'd475; ballX = 10'd300; botPadX = 10'd260;
        applyStimulus(1'b0, 1'b0);
        ballX = 10'd323;
        applyStimulus(1'b0, 1'b0);
        ballY = 10'd471; ballX = 10'd300; botPadX = 10'd0;
        applyStimulus(1'b0, 1'b0);
        ballY = 10'd9; topPadX = 10'd500;
        applyStimulus(1'b0, 1'b0);
        checkOutput("hit_still_play", ballHold, 1'b0);

        // Clean bottom miss: p1 point, then a held miss position over the pause.
        ballY = 10'd475; ballX = 10'd300; botPadX = 10'd0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("p1_hold", ballHold, 1'b1);
        checkOutput("p1_serve", serveDir, 1'b1);
        runFrames(58);
        pulseStart();
        checkOutput("pause_ignores_start", ballHold, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("pause_59", ballHold, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        centreBall();
        pressStart("serve_after_pause");

        // Boundary miss: y at BOTTOM_LIMIT, ball just right of paddle.
        ballY = 10'd472; ballX = 10'd324; botPadX = 10'd260;
        applyStimulus(1'b1, 1'b0);
        centreBall();
        runFrames(60);
        pressStart("serve_after_boundary");

        // Player2 wins with 9 top misses.
        for (int i = 1; i <= 9; i++) begin
            ballY = 10'd8; ballX = 10'd300; topPadX = 10'd500;
            applyStimulus(1'b0, 1'b1);
            checkOutput("p2_serve", serveDir, 1'b0);
            if (i < 9) begin
                checkOutput("p2_not_over", gameOver, 1'b0);
                centreBall();
                runFrames(60);
                pressStart("serve_p2_loop");
            end
        end
        checkOutput("win_gameover", gameOver, 1'b1);
        checkOutput("win_winner", winner, 1'b1);
        checkOutput("win_hold", ballHold, 1'b1);
        ballY = 10'd475; botPadX = 10'd0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("gameover_frame_ignored", gameOver, 1'b1);
        centreBall();
        pulseStart();
        checkOutput("restart_gameover", gameOver, 1'b0);
        checkOutput("restart_hold", ballHold, 1'b1);
        checkOutput("restart_serve", serveDir, 1'b0);
        pressStart("serve_after_restart");
        ballY = 10'd8; topPadX = 10'd500;
        applyStimulus(1'b0, 1'b1);
        checkOutput("tally_cleared", gameOver, 1'b0);
        centreBall();
        runFrames(60);
        pressStart("serve_before_reset");

        // Reset while a score pulse is high.
        ballY = 10'd475; botPadX = 10'd0;
        applyStimulus(1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_pulse_drop", scoreP1, 1'b0);
        checkOutput("rst_hold", ballHold, 1'b1);
        checkOutput("rst_gameover", gameOver, 1'b0);
        checkOutput("rst_serve", serveDir, 1'b0);
        centreBall();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL pulses_missing actual=%0d pending expected=0 pending", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
